udma_hyper_tx_sched: RTL and testbench

Transaction scheduler in front of the HyperBus TX data path.
- Arbitrates round-robin between two uDMA TX requesters.
- Splits each granted transfer into bursts that never cross a BURST_MAX-byte boundary and issues one PHY command per burst.
- Drives the TX buffer sideband signals: handshake pulse, remaining-byte count, odd-start flag and mem_sel. Tracks beats to sequence the bursts.

---
 rtl/udma_hyper_pkg.sv | 14 +
 rtl/udma_hyper_burst_calc.sv | 25 ++
 rtl/udma_hyper_tx_sched.sv | 155 +++++++++++++++
 tb/tb_udma_hyper_tx_sched.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_hyper_pkg.sv
// Shared types and constants for the HyperBus TX transaction scheduler.
package udma_hyper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } sched_state_e;

    localparam logic [1:0]  MEM_SEL_32B   = 2'b11;
    localparam int unsigned BEAT_BYTES_32 = 4;
    localparam int unsigned BEAT_BYTES_16 = 2;

endpackage

// File: rtl/udma_hyper_burst_calc.sv
// Combinational burst sizing: clips the remaining transfer so a burst never
// crosses a BURST_MAX-byte boundary.
module udma_hyper_burst_calc #(
    parameter int unsigned TRANS_SIZE = 16,
    parameter int unsigned BURST_MAX  = 512
) (
    input  logic [31:0]           addr_i,
    input  logic [TRANS_SIZE-1:0] size_left_i,
    output logic [TRANS_SIZE-1:0] burst_o,
    output logic                  odd_o
);

    localparam logic [31:0] BMAX = 32'(BURST_MAX);

    logic [31:0] offset;
    logic [31:0] room;
    logic [31:0] size_ext;

    assign offset   = addr_i & (BMAX - 32'd1);
    assign room     = BMAX - offset;
    assign size_ext = 32'(size_left_i);
    assign burst_o  = (size_ext < room) ? size_left_i : room[TRANS_SIZE-1:0];
    assign odd_o    = addr_i[0];

endmodule

// File: rtl/udma_hyper_tx_sched.sv
// Round-robin scheduler for two uDMA TX requesters; splits each transfer into
// boundary-aligned PHY bursts and tracks data beats to sequence them.
module udma_hyper_tx_sched
    import udma_hyper_pkg::*;
#(
    parameter int unsigned TRANS_SIZE = 16,
    parameter int unsigned BURST_MAX  = 512
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [1:0]                 req_valid_i,
    output logic [1:0]                 req_ready_o,
    input  logic [1:0][31:0]           req_addr_i,
    input  logic [1:0][TRANS_SIZE-1:0] req_size_i,
    input  logic [1:0][1:0]            req_mem_sel_i,
    input  logic [1:0]                 req_addr_space_i,
    output logic                       phy_trans_valid_o,
    input  logic                       phy_trans_ready_i,
    output logic [31:0]                phy_addr_o,
    output logic [TRANS_SIZE-1:0]      phy_burst_o,
    output logic [1:0]                 mem_sel_o,
    output logic                       addr_space_o,
    output logic                       trans_handshake_o,
    output logic [TRANS_SIZE-1:0]      remained_data_o,
    output logic                       odd_saaddr_o,
    input  logic                       tx_beat_i,
    output logic                       grant_o,
    output logic                       busy_o,
    output logic                       done_o
);

    sched_state_e          state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  grant_q, grant_d;
    logic                  gnt;
    logic [31:0]           addr_q, addr_d;
    logic [TRANS_SIZE-1:0] size_q, size_d;
    logic [TRANS_SIZE-1:0] remained_q, remained_d;
    logic [TRANS_SIZE-1:0] burst;
    logic [TRANS_SIZE-1:0] beat;
    logic [1:0]            mem_sel_q, mem_sel_d;
    logic                  space_q, space_d;
    logic                  done_q, done_d;
    logic                  odd;

    udma_hyper_burst_calc #(
        .TRANS_SIZE (TRANS_SIZE),
        .BURST_MAX  (BURST_MAX)
    ) i_burst_calc (
        .addr_i      (addr_q),
        .size_left_i (size_q),
        .burst_o     (burst),
        .odd_o       (odd)
    );

    // A lone requester wins outright; with both pending the pointer decides.
    assign gnt  = req_valid_i[1] & (~req_valid_i[0] | rr_q);
    assign beat = (mem_sel_q == MEM_SEL_32B) ? TRANS_SIZE'(BEAT_BYTES_32)
                                             : TRANS_SIZE'(BEAT_BYTES_16);

    always_comb begin
        state_d           = state_q;
        rr_d              = rr_q;
        grant_d           = grant_q;
        addr_d            = addr_q;
        size_d            = size_q;
        remained_d        = remained_q;
        mem_sel_d         = mem_sel_q;
        space_d           = space_q;
        done_d            = 1'b0;
        req_ready_o       = 2'b00;
        phy_trans_valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    req_ready_o[gnt] = 1'b1;
                    rr_d             = ~gnt;
                    grant_d          = gnt;
                    addr_d           = req_addr_i[gnt];
                    size_d           = req_size_i[gnt];
                    mem_sel_d        = req_mem_sel_i[gnt];
                    space_d          = req_addr_space_i[gnt];
                    if (req_size_i[gnt] == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                phy_trans_valid_o = 1'b1;
                if (phy_trans_ready_i) begin
                    remained_d = burst;
                    state_d    = DATA;
                end
            end
            DATA: begin
                // The last beat of a burst may carry padding, so it clears the count.
                if (tx_beat_i) begin
                    if (remained_q <= beat) begin
                        remained_d = '0;
                        addr_d     = addr_q + 32'(burst);
                        size_d     = size_q - burst;
                        if (size_q == burst) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = ISSUE;
                        end
                    end else begin
                        remained_d = remained_q - beat;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            grant_q    <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            remained_q <= '0;
            mem_sel_q  <= 2'b00;
            space_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            remained_q <= remained_d;
            mem_sel_q  <= mem_sel_d;
            space_q    <= space_d;
            done_q     <= done_d;
        end
    end

    assign phy_addr_o        = addr_q;
    assign phy_burst_o       = burst;
    assign odd_saaddr_o      = odd;
    assign mem_sel_o         = mem_sel_q;
    assign addr_space_o      = space_q;
    assign trans_handshake_o = phy_trans_valid_o & phy_trans_ready_i;
    assign remained_data_o   = remained_q;
    assign grant_o           = grant_q;
    assign busy_o            = (state_q != IDLE);
    assign done_o            = done_q;

endmodule

// File: tb/tb_udma_hyper_tx_sched.sv
// Directed self-checking bench for the HyperBus TX scheduler.
module tb_udma_hyper_tx_sched;

    localparam int TS = 16;

    logic              clk_i;
    logic              rst_ni;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  req_addr;
    logic [1:0][TS-1:0] req_size;
    logic [1:0][1:0]   req_mem_sel;
    logic [1:0]        req_space;
    logic              phy_valid;
    logic              phy_ready;
    logic [31:0]       phy_addr;
    logic [TS-1:0]     phy_burst;
    logic [1:0]        mem_sel;
    logic              addr_space;
    logic              handshake;
    logic [TS-1:0]     remained;
    logic              odd;
    logic              tx_beat;
    logic              grant;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    udma_hyper_tx_sched #(
        .TRANS_SIZE (TS),
        .BURST_MAX  (512)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_addr_i        (req_addr),
        .req_size_i        (req_size),
        .req_mem_sel_i     (req_mem_sel),
        .req_addr_space_i  (req_space),
        .phy_trans_valid_o (phy_valid),
        .phy_trans_ready_i (phy_ready),
        .phy_addr_o        (phy_addr),
        .phy_burst_o       (phy_burst),
        .mem_sel_o         (mem_sel),
        .addr_space_o      (addr_space),
        .trans_handshake_o (handshake),
        .remained_data_o   (remained),
        .odd_saaddr_o      (odd),
        .tx_beat_i         (tx_beat),
        .grant_o           (grant),
        .busy_o            (busy),
        .done_o            (done)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (done) done_cnt++;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni      = 1'b1;
        req_valid   = 2'b00;
        req_addr    = '0;
        req_size    = '0;
        req_mem_sel = '0;
        req_space   = 2'b00;
        phy_ready   = 1'b0;
        tx_beat     = 1'b0;
        #1 rst_ni = 1'b0;
        #12;
        checks++;
        if ({req_ready, phy_valid, handshake, odd, grant, busy, done} !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%b exp=0", {req_ready, phy_valid, handshake, odd, grant, busy, done});
        end
        checks++;
        if ({phy_addr, phy_burst, remained, mem_sel, addr_space} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data addr=%h burst=%0d rem=%0d ms=%b sp=%b exp=0", phy_addr, phy_burst, remained, mem_sel, addr_space);
        end
        #9 rst_ni = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        int start;
        phy_ready      = 1'b1;
        req_addr[0]    = 32'h100;
        req_size[0]    = 16'd64;
        req_mem_sel[0] = 2'b11;
        req_valid      = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL single_ready got=%b exp=01", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        checks++;
        if ({phy_valid, handshake, phy_addr, phy_burst} !== {1'b1, 1'b1, 32'h100, 16'd64}) begin
            failures++;
            $display("[TB] FAIL single_cmd got v=%b hs=%b addr=%h burst=%0d exp v=1 hs=1 addr=100 burst=64", phy_valid, handshake, phy_addr, phy_burst);
        end
        cyc();
        #1;
        checks++;
        if ({phy_valid, handshake, remained} !== {1'b0, 1'b0, 16'd64}) begin
            failures++;
            $display("[TB] FAIL single_data_entry got v=%b hs=%b rem=%0d exp v=0 hs=0 rem=64", phy_valid, handshake, remained);
        end
        start   = done_cnt;
        tx_beat = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            checks++;
            if (remained !== 16'(64 - 4 * (i + 1))) begin
                failures++;
                $display("[TB] FAIL single_rem beat=%0d got=%0d exp=%0d", i + 1, remained, 64 - 4 * (i + 1));
            end
            checks++;
            if (done !== (i == 15)) begin
                failures++;
                $display("[TB] FAIL single_done beat=%0d got=%b exp=%b", i + 1, done, (i == 15));
            end
        end
        tx_beat = 1'b0;
        cyc();
        checks++;
        if ({done, busy} !== 2'b00 || done_cnt - start !== 1) begin
            failures++;
            $display("[TB] FAIL single_end done=%b busy=%b pulses=%0d exp 0 0 1", done, busy, done_cnt - start);
        end
    endtask

    task automatic test_boundary();
        int start;
        start          = done_cnt;
        req_addr[1]    = 32'h1F0;
        req_size[1]    = 16'd40;
        req_mem_sel[1] = 2'b01;
        req_space[1]   = 1'b1;
        req_valid      = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("[TB] FAIL bnd_ready got=%b exp=10", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        checks++;
        if ({phy_valid, phy_addr, phy_burst, grant, mem_sel, addr_space} !== {1'b1, 32'h1F0, 16'd16, 1'b1, 2'b01, 1'b1}) begin
            failures++;
            $display("[TB] FAIL bnd_cmd1 got v=%b addr=%h burst=%0d g=%b ms=%b sp=%b exp 1 1f0 16 1 01 1", phy_valid, phy_addr, phy_burst, grant, mem_sel, addr_space);
        end
        cyc();
        tx_beat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (remained !== 16'(16 - 2 * (i + 1))) begin
                failures++;
                $display("[TB] FAIL bnd_rem1 beat=%0d got=%0d exp=%0d", i + 1, remained, 16 - 2 * (i + 1));
            end
        end
        #1;
        checks++;
        if ({phy_valid, phy_addr, phy_burst, done} !== {1'b1, 32'h200, 16'd24, 1'b0}) begin
            failures++;
            $display("[TB] FAIL bnd_cmd2 got v=%b addr=%h burst=%0d done=%b exp 1 200 24 0", phy_valid, phy_addr, phy_burst, done);
        end
        cyc();
        checks++;
        if (remained !== 16'd24) begin failures++; $display("[TB] FAIL bnd_beat_in_issue got=%0d exp=24", remained); end
        for (int i = 0; i < 12; i++) begin
            cyc();
            checks++;
            if (remained !== 16'(24 - 2 * (i + 1))) begin
                failures++;
                $display("[TB] FAIL bnd_rem2 beat=%0d got=%0d exp=%0d", i + 1, remained, 24 - 2 * (i + 1));
            end
        end
        tx_beat = 1'b0;
        cyc();
        cyc();
        checks++;
        if (done_cnt - start !== 1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bnd_done pulses=%0d busy=%b exp 1 0", done_cnt - start, busy);
        end
    endtask

    task automatic test_arbitration();
        req_size    = '0;
        req_addr    = '0;
        req_valid   = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL arb_first got=%b exp=01", req_ready); end
        cyc();
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10 || grant !== 1'b0) begin
            failures++;
            $display("[TB] FAIL arb_second ready=%b grant=%b exp 10 0", req_ready, grant);
        end
        cyc();
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01 || grant !== 1'b1) begin
            failures++;
            $display("[TB] FAIL arb_third ready=%b grant=%b exp 01 1", req_ready, grant);
        end
        cyc();
        req_valid = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b00 || grant !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL arb_idle ready=%b grant=%b busy=%b exp 00 0 0", req_ready, grant, busy);
        end
        cyc();
    endtask

    task automatic test_odd_stall();
        phy_ready      = 1'b0;
        req_addr[0]    = 32'h101;
        req_size[0]    = 16'd6;
        req_mem_sel[0] = 2'b11;
        req_valid      = 2'b01;
        cyc();
        req_valid = 2'b00;
        #1;
        checks++;
        if ({phy_valid, handshake, odd, phy_addr, phy_burst} !== {1'b1, 1'b0, 1'b1, 32'h101, 16'd6}) begin
            failures++;
            $display("[TB] FAIL odd_cmd got v=%b hs=%b odd=%b addr=%h burst=%0d exp 1 0 1 101 6", phy_valid, handshake, odd, phy_addr, phy_burst);
        end
        cyc();
        phy_ready = 1'b1;
        #1;
        checks++;
        if ({phy_valid, handshake, phy_addr} !== {1'b1, 1'b1, 32'h101}) begin
            failures++;
            $display("[TB] FAIL odd_stall got v=%b hs=%b addr=%h exp 1 1 101", phy_valid, handshake, phy_addr);
        end
        cyc();
        checks++;
        if (remained !== 16'd6) begin failures++; $display("[TB] FAIL odd_rem0 got=%0d exp=6", remained); end
        tx_beat = 1'b1;
        cyc();
        checks++;
        if (remained !== 16'd2) begin failures++; $display("[TB] FAIL odd_rem1 got=%0d exp=2", remained); end
        cyc();
        tx_beat = 1'b0;
        checks++;
        if (remained !== 16'd0 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL odd_rem2 rem=%0d done=%b exp 0 1", remained, done);
        end
        cyc();
    endtask

    task automatic test_zero_size();
        req_size[1] = 16'd0;
        req_valid   = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10 || phy_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_grant ready=%b v=%b exp 10 0", req_ready, phy_valid);
        end
        cyc();
        req_valid = 2'b00;
        #1;
        checks++;
        if ({done, phy_valid, busy} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL zero_done got done=%b v=%b busy=%b exp 1 0 0", done, phy_valid, busy);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        req_addr[1]    = 32'h400;
        req_size[1]    = 16'd64;
        req_mem_sel[1] = 2'b11;
        req_space[1]   = 1'b1;
        req_valid      = 2'b10;
        cyc();
        req_valid = 2'b00;
        cyc();
        tx_beat = 1'b1;
        for (int i = 0; i < 11; i++) cyc();
        checks++;
        if (remained !== 16'd20 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_pre rem=%0d busy=%b exp 20 1", remained, busy);
        end
        tx_beat = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({req_ready, phy_valid, handshake, odd, grant, busy, done, mem_sel, addr_space} !== 11'd0) begin
            failures++;
            $display("[TB] FAIL mid_rst_ctrl got=%b exp=0", {req_ready, phy_valid, handshake, odd, grant, busy, done, mem_sel, addr_space});
        end
        checks++;
        if ({phy_addr, phy_burst, remained} !== '0) begin
            failures++;
            $display("[TB] FAIL mid_rst_data addr=%h burst=%0d rem=%0d exp 0", phy_addr, phy_burst, remained);
        end
        #3 rst_ni = 1'b1;
        cyc();
        req_addr[0]    = 32'h20;
        req_size[0]    = 16'd4;
        req_mem_sel[0] = 2'b11;
        req_valid      = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL mid_regrant got=%b exp=01", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        checks++;
        if ({phy_valid, phy_addr, phy_burst, grant} !== {1'b1, 32'h20, 16'd4, 1'b0}) begin
            failures++;
            $display("[TB] FAIL mid_cmd got v=%b addr=%h burst=%0d g=%b exp 1 20 4 0", phy_valid, phy_addr, phy_burst, grant);
        end
        cyc();
        tx_beat = 1'b1;
        cyc();
        tx_beat = 1'b0;
        checks++;
        if (remained !== 16'd0 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_done rem=%0d done=%b exp 0 1", remained, done);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_arbitration();
        test_odd_stall();
        test_zero_size();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
